alu_operand_loader: RTL and testbench

Sequential front end for the 4-bit ALU stage: it takes a single raw push-button and a 4-bit switch bank, debounces the button, and steps through an entry sequence. The sequence latches operand A, operand B and the 3-bit opcode from the switches, one per accepted press. It then presents a stable `{a, b, op}` triple with `valid` to the ALU, whose 7-segment output displays the result.

---
 rtl/alu_operand_loader.sv | 127 ++++++++++++
 tb/tb_alu_operand_loader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// Operand entry front end for the 4-bit ALU: debounces one push-button and latches A, B and opcode from the switches.
// Define ALU_LOADER_SYNC_EN to put a two-flop synchronizer in front of the debouncer.
//
//   state   | meaning
//   --------+-------------------------------------------
//   LOAD_A  | waiting for the press that latches operand A
//   LOAD_B  | waiting for the press that latches operand B
//   LOAD_OP | waiting for the press that latches the opcode
//   READY   | complete triple held, valid high
module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [3:0] sw,
  input  logic       clr,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] op,
  output logic       valid,
  output logic [1:0] state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    READY   = 2'd3
  } state_t;

  state_t        state_q, state_nxt;
  logic [3:0]    a_nxt, b_nxt;
  logic [2:0]    op_nxt;
  logic          valid_nxt;
  logic          s;
  logic          lvl;
  logic [CW-1:0] cnt;
  logic          press;

`ifdef ALU_LOADER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], btn};
  end

  assign s = sync_q[1];
`else
  assign s = btn;
`endif

  // Any sample matching the accepted level restarts the persistence count.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl <= 1'b0;
      cnt <= '0;
    end else if (s == lvl) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      lvl <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign press = s & ~lvl & (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      a       <= '0;
      b       <= '0;
      op      <= '0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      a       <= a_nxt;
      b       <= b_nxt;
      op      <= op_nxt;
      valid   <= valid_nxt;
    end
  end

  // clr swallows a coincident press; the debouncer still takes the new level.
  always_comb begin
    state_nxt = state_q;
    a_nxt     = a;
    b_nxt     = b;
    op_nxt    = op;
    if (clr) begin
      state_nxt = LOAD_A;
      a_nxt     = '0;
      b_nxt     = '0;
      op_nxt    = '0;
    end else if (press) begin
      case (state_q)
        LOAD_A: begin
          a_nxt     = sw;
          state_nxt = LOAD_B;
        end
        LOAD_B: begin
          b_nxt     = sw;
          state_nxt = LOAD_OP;
        end
        LOAD_OP: begin
          op_nxt    = sw[2:0];
          state_nxt = READY;
        end
        READY: begin
          a_nxt     = sw;
          state_nxt = LOAD_B;
        end
        default: state_nxt = LOAD_A;
      endcase
    end
    valid_nxt = (state_nxt == READY);
  end

  assign state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader; adapts expected capture latency when ALU_LOADER_SYNC_EN is defined.
module tb_alu_operand_loader;

`ifdef ALU_LOADER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, btn, clr, btn_f;
  logic [3:0] sw;
  logic [3:0] a, b, a_f, b_f;
  logic [2:0] op, op_f;
  logic       valid, valid_f;
  logic [1:0] state, state_f;

  int n_cmp = 0;
  int n_err = 0;

  alu_operand_loader #(.DEBOUNCE_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .btn(btn), .sw(sw), .clr(clr),
    .a(a), .b(b), .op(op), .valid(valid), .state(state)
  );

  alu_operand_loader #(.DEBOUNCE_CYCLES(1)) u_fast (
    .clk(clk), .rst(rst), .btn(btn_f), .sw(sw), .clr(clr),
    .a(a_f), .b(b_f), .op(op_f), .valid(valid_f), .state(state_f)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Press lasting 6+LAT high cycles; capture expected on the (4+LAT)th edge.
  task automatic press_chk(input string tag, input logic [3:0] swv,
                           input logic [1:0] st_before, input logic [1:0] st_after);
    sw  = swv;
    btn = 1'b1;
    repeat (3 + LAT) tick();
    chk({tag, "_pre"}, state, st_before);
    tick();
    chk({tag, "_cap"}, state, st_after);
    repeat (2) tick();
    btn = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    logic [7:0] pat;
    logic [1:0] prev;
    int         n_adv;

    rst = 1'b1; btn = 1'b0; btn_f = 1'b0; clr = 1'b0; sw = 4'h0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_a", a, 4'h0);
    chk("rst_b", b, 4'h0);
    chk("rst_op", op, 3'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_state", state, 2'd0);

    // Three clean presses
    press_chk("p1", 4'h5, 2'd0, 2'd1);
    chk("p1_a", a, 4'h5);
    press_chk("p2", 4'h3, 2'd1, 2'd2);
    chk("p2_b", b, 4'h3);
    chk("p2_valid", valid, 1'b0);
    press_chk("p3", 4'h1, 2'd2, 2'd3);
    chk("p3_a", a, 4'h5);
    chk("p3_b", b, 4'h3);
    chk("p3_op", op, 3'h1);
    chk("p3_valid", valid, 1'b1);

    // Re-entry from READY
    press_chk("rd", 4'h9, 2'd3, 2'd1);
    chk("rd_a", a, 4'h9);
    chk("rd_valid", valid, 1'b0);
    chk("rd_b", b, 4'h3);
    chk("rd_op", op, 3'h1);

    // Bouncy press: 1,1,1,0,1,1,1,1 -> single capture on the final 1
    pat = 8'b1110_1111;
    sw  = 4'hA;
    for (int i = 0; i < 8; i++) begin
      btn = pat[7-i];
      tick();
      if (i < 7) chk("bnc_early", state, 2'd1);
    end
    repeat (LAT) tick();
    chk("bnc_state", state, 2'd2);
    chk("bnc_b", b, 4'hA);
    btn = 1'b0;
    repeat (8) tick();

    // clr coincident with acceptance in LOAD_OP; sw[3] set to expose op width
    sw  = 4'hE;
    btn = 1'b1;
    repeat (3 + LAT) tick();
    chk("clr_pre", state, 2'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_a", a, 4'h0);
    chk("clr_b", b, 4'h0);
    chk("clr_op", op, 3'h0);
    chk("clr_valid", valid, 1'b0);
    chk("clr_state", state, 2'd0);
    repeat (10) tick();
    chk("clr_held", state, 2'd0);
    btn = 1'b0;
    repeat (8) tick();

    // Long hold and release: exactly one advance
    sw    = 4'h7;
    btn   = 1'b1;
    n_adv = 0;
    prev  = state;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) btn = 1'b0;
      tick();
      if (state != prev) n_adv++;
      prev = state;
    end
    chk("hold_events", n_adv[7:0], 8'd1);
    chk("hold_a", a, 4'h7);

    // op capture ignores sw[3]: go to LOAD_OP then capture 4'hE -> op 6
    press_chk("w1", 4'h2, 2'd1, 2'd2);
    press_chk("w2", 4'hE, 2'd2, 2'd3);
    chk("w_op", op, 3'h6);

    // Reset mid-debounce with button held across deassertion
    sw  = 4'hB;
    btn = 1'b1;
    repeat (2 + LAT) tick();
    rst = 1'b1;
    tick();
    chk("mrst_state", state, 2'd0);
    chk("mrst_a", a, 4'h0);
    rst = 1'b0;
    repeat (3 + LAT) tick();
    chk("mrst_pre", state, 2'd0);
    tick();
    chk("mrst_cap", state, 2'd1);
    chk("mrst_a2", a, 4'hB);
    btn = 1'b0;
    repeat (8) tick();

    // DEBOUNCE_CYCLES = 1 accepts the first differing sample
    sw    = 4'hC;
    btn_f = 1'b1;
    repeat (LAT) tick();
    chk("fast_pre", state_f, 2'd0);
    tick();
    chk("fast_state", state_f, 2'd1);
    chk("fast_a", a_f, 4'hC);
    btn_f = 1'b0;
    repeat (4) tick();
    chk("fast_rel", state_f, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
